// File: rtl/flags_image_tx.sv
// Flags image transmitter: captures compressed status + DF on request and streams the
// AH / FLAGS16 / EFLAGS32 image little-endian, one byte per accepted handshake.
module flags_image_tx #(
  parameter logic [11:0] IOPL_IF_IMAGE = 12'h200,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [5:0]       status_in,
  input  logic             df_in,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] img_count
);

  // Bit positions inside the compressed status word
  localparam int STAT_CF = 0;
  localparam int STAT_PF = 1;
  localparam int STAT_AF = 2;
  localparam int STAT_ZF = 3;
  localparam int STAT_SF = 4;
  localparam int STAT_OF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [31:0] img;
  logic [1:0]  idx;
  logic [1:0]  last_idx;
  logic        accept;
  logic        xfer;

  function automatic logic [31:0] build_image(input logic [5:0] st, input logic df);
    logic [31:0] im;
    im     = {20'd0, IOPL_IF_IMAGE};
    im[0]  = st[STAT_CF];
    im[1]  = 1'b1;
    im[2]  = st[STAT_PF];
    im[4]  = st[STAT_AF];
    im[6]  = st[STAT_ZF];
    im[7]  = st[STAT_SF];
    im[10] = df;
    im[11] = st[STAT_OF];
    return im;
  endfunction

  assign accept = req_valid & req_ready;
  assign xfer   = byte_valid & byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      img       <= '0;
      idx       <= '0;
      last_idx  <= '0;
      img_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        img <= build_image(status_in, df_in);
        idx <= '0;
        case (req_mode)
          2'd1:    last_idx <= 2'd1;
          2'd2:    last_idx <= 2'd3;
          default: last_idx <= 2'd0;
        endcase
      end else if (xfer) begin
        idx <= idx + 2'd1;
      end
      if (done && (img_count != {CNT_W{1'b1}}))
        img_count <= img_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    byte_last  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (req_mode == 2'd3) ? ERR : SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        byte_data  = img[{idx, 3'b000} +: 8];
        byte_last  = (idx == last_idx);
        if (byte_ready && byte_last) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flags_image_tx.sv
// Directed bench for flags_image_tx; a second narrow-counter instance exercises saturation.
module tb_flags_image_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_mode;
  logic [5:0]  status_in;
  logic        df_in;
  logic        byte_ready;

  logic        req_ready, byte_valid, byte_last, done, err;
  logic [7:0]  byte_data;
  logic [15:0] img_count;

  logic        s_req_ready, s_byte_valid, s_byte_last, s_done, s_err;
  logic [7:0]  s_byte_data;
  logic [3:0]  s_img_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  flags_image_tx #(.IOPL_IF_IMAGE(12'h200), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .status_in(status_in), .df_in(df_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .done(done), .err(err), .img_count(img_count)
  );

  flags_image_tx #(.IOPL_IF_IMAGE(12'h200), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_mode(req_mode), .status_in(status_in), .df_in(df_in),
    .byte_valid(s_byte_valid), .byte_ready(byte_ready), .byte_data(s_byte_data),
    .byte_last(s_byte_last), .done(s_done), .err(s_err), .img_count(s_img_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and drain the image; status/df are scrambled after accept.
  task automatic run_img(input logic [1:0] mode, input logic [5:0] st, input logic df,
                         input logic [31:0] exp_img, input int nbytes, input int stall);
    req_valid  = 1'b1;
    req_mode   = mode;
    status_in  = st;
    df_in      = df;
    byte_ready = 1'b0;
    #1 chk("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    status_in = ~st;
    df_in     = ~df;
    for (int b = 0; b < nbytes; b++) begin
      for (int s = 0; s < stall; s++) begin
        byte_ready = 1'b0;
        #1;
        chk("stall_valid", byte_valid, 1);
        chk("stall_data", byte_data, exp_img[8*b +: 8]);
        chk("stall_last", byte_last, (b == nbytes - 1));
        chk("stall_done", done, 0);
        chk("busy_req_ready", req_ready, 0);
        step();
      end
      byte_ready = 1'b1;
      #1;
      chk("byte_valid", byte_valid, 1);
      chk("byte_data", byte_data, exp_img[8*b +: 8]);
      chk("byte_last", byte_last, (b == nbytes - 1));
      chk("done_pulse", done, (b == nbytes - 1));
      step();
    end
    byte_ready = 1'b0;
    exp_count++;
    #1;
    chk("img_count", img_count, exp_count);
    chk("post_valid", byte_valid, 0);
    chk("post_done", done, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_mode = 2'd0; status_in = 6'd0;
    df_in = 1'b0; byte_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valid", byte_valid, 0);
    chk("rst_last", byte_last, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", img_count, 0);

    // Reset mid-stream: mode2, status all ones, DF=1 -> image 0x00000ED7
    req_valid = 1'b1; req_mode = 2'd2; status_in = 6'h3F; df_in = 1'b1;
    step();
    req_valid = 1'b0; byte_ready = 1'b1;
    #1 chk("abort_b0", byte_data, 8'hD7);
    step();
    #1 chk("abort_b1", byte_data, 8'h0E);
    step();
    byte_ready = 1'b0; rst = 1'b1;
    #1 chk("abort_b2_valid", byte_valid, 1);
    step();
    rst = 1'b0;
    #1;
    chk("abort_valid", byte_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_data", byte_data, 0);
    chk("abort_done", done, 0);
    chk("abort_count", img_count, 0);

    // AH byte: CF=1 ZF=1 -> 0x43
    run_img(2'd0, 6'b001001, 1'b0, 32'h0000_0243, 1, 0);
    // EFLAGS32: OF=1 SF=1 DF=1 -> 82 0E 00 00
    run_img(2'd2, 6'b110000, 1'b1, 32'h0000_0E82, 4, 0);
    // FLAGS16 with a slow sink: PF=1 AF=1 -> 16 02
    run_img(2'd1, 6'b000110, 1'b0, 32'h0000_0216, 2, 3);

    // Illegal mode
    req_valid = 1'b1; req_mode = 2'd3; status_in = 6'h3F; df_in = 1'b1;
    byte_ready = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    chk("err_pulse", err, 1);
    chk("err_valid", byte_valid, 0);
    chk("err_req_ready", req_ready, 0);
    step();
    #1;
    chk("err_clear", err, 0);
    chk("err_valid2", byte_valid, 0);
    chk("err_req_back", req_ready, 1);
    chk("err_count", img_count, exp_count);
    byte_ready = 1'b0;

    // Saturation on the 4-bit instance: fill to 15, then one more completion
    for (int i = 0; i < 12; i++)
      run_img(2'd0, 6'b000000, 1'b0, 32'h0000_0202, 1, 0);
    chk("sat_full", s_img_count, 4'hF);
    run_img(2'd0, 6'b000000, 1'b0, 32'h0000_0202, 1, 0);
    chk("sat_hold", s_img_count, 4'hF);
    chk("wide_count", img_count, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
